tile_loader: RTL and testbench
==============================

// Module: tile_loader
// PURPOSE
//  Parametrised DRAM-to-tile loader, successor of the single-byte-latency matrix loader.
//  - Reads a contiguous run of `length` elements from a byte-wide external memory port starting at `dram_addr`.
//  - Packs the bytes MSB-first into TILE_WIDTH-bit tiles and streams them out over a valid/ready handshake.
//  - Sits between the instruction execution unit and the compute engines' tile buffers.
//  - New behaviour: any read latency, backpressure, no reads past the end, last-tile flag, optional prefetch.
// PARAMETERS
//  TILE_WIDTH  256  tile width in bits; multiple of 8; NUM_BYTES = TILE_WIDTH/8
//  ELEM_WIDTH  8    element width in bits; multiple of 8
//  ADDR_WIDTH  24   memory byte-address width
//  LEN_WIDTH   20   width of the length field (elements)
//  MEM_LATENCY 1    cycles from mem_rd_en/mem_addr to valid mem_rdata; 1..4
// PORTS
//  clk        in   1           clock, rising edge
//  rst        in   1           reset; asynchronous, active-high
//  start      in   1           launch a transfer; sampled only in IDLE
//  dram_addr  in   ADDR_WIDTH  first byte address
//  length     in   LEN_WIDTH   number of elements
//  busy       out  1           high from the cycle after accepted start through DONE
//  mem_rd_en  out  1           memory read strobe
//  mem_addr   out  ADDR_WIDTH  memory byte address, valid when mem_rd_en=1
//  mem_rdata  in   8           read data, MEM_LATENCY cycles after the strobe
//  tile_data  out  TILE_WIDTH  tile; byte k of the tile at bits [TILE_WIDTH-1-8k -: 8]
//  tile_valid out  1           tile_data valid
//  tile_ready in   1           consumer accepts the tile when tile_valid and tile_ready are both high
//  tile_last  out  1           qualifies tile_valid: final tile of the transfer
//  done       out  1           one-cycle pulse when the transfer completes
// BEHAVIOUR
//  - Reset values: all outputs 0. Counters, delay line and tile registers cleared. State = IDLE.
//  - Sizing:
//    - total_bytes = length*ELEM_WIDTH/8.
//    - num_tiles = ceil(total_bytes/NUM_BYTES).
//    - Arithmetic is carried in LEN_WIDTH+$clog2(ELEM_WIDTH)+1 bits, so no overflow.
//  - FSM states: IDLE, FETCH, OUT, DONE.
//  - IDLE:
//    - start=1 latches dram_addr and length.
//    - length==0: go to DONE with no tiles and no memory reads.
//    - otherwise: go to FETCH.
//  - FETCH issues one slot per cycle for byte index i = 0..NUM_BYTES-1 of the current tile.
//    - Global byte g < total_bytes: mem_rd_en=1, mem_addr = base+g.
//    - Otherwise the slot is a pad slot: mem_rd_en=0, and the byte is written 0 on capture.
//    - Each slot enters a MEM_LATENCY-deep delay line carrying {valid, pad, i}.
//    - On exit, byte i of the tile is written with mem_rdata, or with 0 for a pad slot.
//    - When the last slot has been captured, the tile is complete and the FSM goes to OUT.
//    - Fetch time per tile: NUM_BYTES+MEM_LATENCY cycles.
//  - OUT:
//    - tile_valid=1. tile_last=1 on the final tile.
//    - tile_data, tile_valid and tile_last hold stable while tile_ready=0.
//    - On handshake: go to FETCH for the next tile, or to DONE if tile_last was 1.
//  - DONE:
//    - done=1 for exactly one cycle.
//    - busy drops in the following cycle, when the FSM returns to IDLE.
//  - start while busy: ignored, no effect on the running transfer.
//  - Addresses wrap modulo 2^ADDR_WIDTH.
//  - rst mid-transfer: immediate abort to IDLE, outputs 0.
//    - In-flight read data arriving after reset is discarded.
// CONFIGURATION
//  - TILE_LOADER_PREFETCH_EN defined:
//    - A second tile buffer is added.
//    - FETCH of tile n+1 runs while tile n waits in OUT.
//    - On handshake, a completed prefetched tile appears on tile_data in the next cycle (tile_valid stays 1).
//    - No prefetch is done past the last tile.
//    - Steady-state throughput with tile_ready=1 is one tile per NUM_BYTES cycles.
//  - TILE_LOADER_PREFETCH_EN undefined:
//    - Single buffer. Fetch stalls while in OUT.
//    - Per-tile period is NUM_BYTES+MEM_LATENCY+1 cycles, plus any ready stall.
//    - Tile order, data and zero padding are identical in both builds.
// TESTING
//  Bench settings: TILE_WIDTH=32 (NUM_BYTES=4), memory byte at address a = a[7:0], unless a scenario says otherwise.
//  1. addr=0x10, length=8, ELEM_WIDTH=8, tile_ready=1 -> tiles 0x10111213 then 0x14151617 (tile_last=1); 1 done pulse.
//  2. addr=0x20, length=5 -> tiles 0x20212223 then 0x24000000 (last); mem_rd_en asserted exactly 5 times.
//  3. length=4, tile_ready held 0 for 10 cycles -> tile_data=0x00010203 stable, tile_valid=1 throughout; accepted on ready.
//  4. MEM_LATENCY=3, ELEM_WIDTH=16, length=2, addr=0x40 -> single tile 0x40414243, tile_last=1.
//  5. length=0 -> no mem_rd_en, no tile_valid, done pulses within 2 cycles of start.
//  6. rst asserted in FETCH of tile 2 -> all outputs 0 at once; a new start afterwards yields correct tiles.

Source files
------------

// File: rtl/tile_loader.sv
// tile_loader: reads a contiguous DRAM byte run and streams it as MSB-first packed tiles (IDLE->FETCH->OUT->DONE).
// Optional TILE_LOADER_PREFETCH_EN adds a second buffer so the next tile is fetched while one waits in OUT.
module tile_loader #(
  parameter int TILE_WIDTH  = 256,
  parameter int ELEM_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 24,
  parameter int LEN_WIDTH   = 20,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] dram_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [7:0]            mem_rdata,
  output logic [TILE_WIDTH-1:0] tile_data,
  output logic                  tile_valid,
  input  logic                  tile_ready,
  output logic                  tile_last,
  output logic                  done
);
  localparam int NB = TILE_WIDTH / 8;
  localparam int EB = ELEM_WIDTH / 8;
  localparam int CW = LEN_WIDTH + $clog2(ELEM_WIDTH) + 1;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
`ifdef TILE_LOADER_PREFETCH_EN
  localparam int MAX_PEND = 2;
`else
  localparam int MAX_PEND = 1;
`endif

  typedef enum logic [1:0] {IDLE, FETCH, OUT, DONE} state_t;
  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] base_addr;
  logic [CW-1:0]         total_bytes, cur_base, next_base, out_base, g;
  logic [IW-1:0]         slot_cnt;
  logic                  iss_act, pad, tile_end, start_tile, handshake, active, cap_last;
  logic                  fbuf_full;
  logic [1:0]            pend;
  logic                  dl_v [MEM_LATENCY];
  logic                  dl_p [MEM_LATENCY];
  logic [IW-1:0]         dl_i [MEM_LATENCY];
  logic [TILE_WIDTH-1:0] fbuf, fbuf_nxt;

  assign active     = (state == FETCH) || (state == OUT);
  assign g          = cur_base + CW'(slot_cnt);
  assign pad        = (g >= total_bytes);
  assign tile_end   = iss_act && (slot_cnt == IW'(NB - 1));
  assign handshake  = tile_valid && tile_ready;
  // pend counts tiles whose fetch has started but which have not yet been handed off
  assign start_tile = active && (!iss_act || tile_end) && (next_base < total_bytes)
                      && ((int'(pend) - int'(handshake)) < MAX_PEND);

  assign mem_rd_en  = iss_act && !pad;
  assign mem_addr   = mem_rd_en ? (base_addr + ADDR_WIDTH'(g)) : '0;
  assign cap_last   = dl_v[MEM_LATENCY-1] && (dl_i[MEM_LATENCY-1] == IW'(NB - 1));

  assign busy       = (state != IDLE);
  assign tile_valid = (state == OUT);
  assign done       = (state == DONE);
  assign tile_last  = tile_valid && ((out_base + CW'(NB)) >= total_bytes);

  always_comb begin
    fbuf_nxt = fbuf;
    if (dl_v[MEM_LATENCY-1])
      fbuf_nxt[TILE_WIDTH-1-8*int'(dl_i[MEM_LATENCY-1]) -: 8] =
        dl_p[MEM_LATENCY-1] ? 8'h00 : mem_rdata;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = (length == '0) ? DONE : FETCH;
      FETCH: if (cap_last) state_nxt = OUT;
      OUT: begin
        if (handshake) begin
          if (tile_last)                  state_nxt = DONE;
          else if (fbuf_full || cap_last) state_nxt = OUT;
          else                            state_nxt = FETCH;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      base_addr   <= '0;
      total_bytes <= '0;
      cur_base    <= '0;
      next_base   <= '0;
      out_base    <= '0;
      slot_cnt    <= '0;
      iss_act     <= 1'b0;
      pend        <= '0;
      fbuf        <= '0;
      for (int k = 0; k < MEM_LATENCY; k++) begin
        dl_v[k] <= 1'b0;
        dl_p[k] <= 1'b0;
        dl_i[k] <= '0;
      end
    end else begin
      state   <= state_nxt;
      fbuf    <= fbuf_nxt;
      dl_v[0] <= iss_act;
      dl_p[0] <= pad;
      dl_i[0] <= slot_cnt;
      for (int k = 1; k < MEM_LATENCY; k++) begin
        dl_v[k] <= dl_v[k-1];
        dl_p[k] <= dl_p[k-1];
        dl_i[k] <= dl_i[k-1];
      end
      if (state == IDLE) begin
        if (start) begin
          base_addr   <= dram_addr;
          total_bytes <= CW'(length) * CW'(EB);
          cur_base    <= '0;
          next_base   <= CW'(NB);
          out_base    <= '0;
          slot_cnt    <= '0;
          iss_act     <= (length != '0);
          pend        <= (length != '0) ? 2'd1 : 2'd0;
        end
      end else begin
        if (start_tile) begin
          iss_act   <= 1'b1;
          slot_cnt  <= '0;
          cur_base  <= next_base;
          next_base <= next_base + CW'(NB);
        end else if (tile_end) begin
          iss_act  <= 1'b0;
          slot_cnt <= '0;
        end else if (iss_act) begin
          slot_cnt <= slot_cnt + IW'(1);
        end
        pend <= pend + (start_tile ? 2'd1 : 2'd0) - (handshake ? 2'd1 : 2'd0);
        if (handshake) out_base <= out_base + CW'(NB);
      end
    end
  end

`ifdef TILE_LOADER_PREFETCH_EN
  logic [TILE_WIDTH-1:0] obuf;

  // A tile completing while the output is still occupied parks in fbuf; no further slots
  // are issued until the output drains, so nothing overwrites it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      obuf      <= '0;
      fbuf_full <= 1'b0;
    end else if (cap_last && ((state == FETCH) || ((state == OUT) && handshake))) begin
      obuf <= fbuf_nxt;
    end else if (fbuf_full && handshake) begin
      obuf      <= fbuf;
      fbuf_full <= 1'b0;
    end else if (cap_last && (state == OUT)) begin
      fbuf_full <= 1'b1;
    end
  end

  assign tile_data = obuf;
`else
  assign fbuf_full = 1'b0;
  assign tile_data = fbuf;
`endif

endmodule

// File: tb/tb_tile_loader.sv
// tb_tile_loader: table of directed transfers plus a reset-abort sequence for tile_loader.
// Instance a: 8-bit elements, latency 1; instance b: 16-bit elements, latency 3; memory byte at a is a[7:0].
module tb_tile_loader;
  localparam int TW = 32;
  localparam int AW = 24;
  localparam int LW = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_a = 1'b0, start_b = 1'b0, tile_ready = 1'b1;
  logic [AW-1:0] dram_addr = '0;
  logic [LW-1:0] length = '0;

  logic          busy_a, rd_a, valid_a, last_a, done_a;
  logic [AW-1:0] maddr_a;
  logic [7:0]    rdata_a;
  logic [TW-1:0] tdata_a;
  logic          busy_b, rd_b, valid_b, last_b, done_b;
  logic [AW-1:0] maddr_b;
  logic [7:0]    rdata_b;
  logic [TW-1:0] tdata_b;

  always #5 clk = ~clk;

  tile_loader #(.TILE_WIDTH(TW), .ELEM_WIDTH(8), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .MEM_LATENCY(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .dram_addr(dram_addr), .length(length),
    .busy(busy_a), .mem_rd_en(rd_a), .mem_addr(maddr_a), .mem_rdata(rdata_a),
    .tile_data(tdata_a), .tile_valid(valid_a), .tile_ready(tile_ready),
    .tile_last(last_a), .done(done_a));

  tile_loader #(.TILE_WIDTH(TW), .ELEM_WIDTH(16), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .MEM_LATENCY(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .dram_addr(dram_addr), .length(length),
    .busy(busy_b), .mem_rd_en(rd_b), .mem_addr(maddr_b), .mem_rdata(rdata_b),
    .tile_data(tdata_b), .tile_valid(valid_b), .tile_ready(tile_ready),
    .tile_last(last_b), .done(done_b));

  // memory models: byte at address a is a[7:0]
  logic [7:0] pipe_a;
  logic [7:0] pipe_b [3];
  always @(posedge clk) begin
    pipe_a    <= rd_a ? maddr_a[7:0] : 8'h00;
    pipe_b[0] <= rd_b ? maddr_b[7:0] : 8'h00;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign rdata_a = pipe_a;
  assign rdata_b = pipe_b[2];

  logic          sel = 1'b0;
  logic          o_busy, o_rd, o_valid, o_last, o_done;
  logic [TW-1:0] o_data;
  always_comb begin
    o_busy = sel ? busy_b  : busy_a;
    o_rd   = sel ? rd_b    : rd_a;
    o_valid= sel ? valid_b : valid_a;
    o_last = sel ? last_b  : last_a;
    o_done = sel ? done_b  : done_a;
    o_data = sel ? tdata_b : tdata_a;
  end

  typedef struct {
    bit            s;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    int            stall;
    int            ntiles;
    int            nreads;
    logic [TW-1:0] t0, t1, t2;
  } vec_t;

  int            checks = 0, errors = 0;
  int            n_tiles, n_reads, n_done, done_cyc, hold_bad, busy_bad;
  bit            timed_out;
  logic [TW-1:0] got [4];
  logic          got_last [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [TW-1:0] exp_tile(input vec_t v, input int i);
    case (i)
      0:       return v.t0;
      1:       return v.t1;
      default: return v.t2;
    endcase
  endfunction

  task automatic run_xfer(input bit s, input logic [AW-1:0] a, input logic [LW-1:0] l, input int stall);
    int  stall_left;
    int  extra;
    bit  finished;
    logic [TW-1:0] held;
    n_tiles = 0; n_reads = 0; n_done = 0; done_cyc = -1; hold_bad = 0; busy_bad = 0;
    for (int i = 0; i < 4; i++) begin got[i] = '0; got_last[i] = 1'b0; end
    stall_left = stall; extra = 0; finished = 1'b0; held = '0;
    sel = s; tile_ready = 1'b1;
    @(negedge clk);
    dram_addr = a; length = l;
    if (s) start_b = 1'b1; else start_a = 1'b1;
    for (int c = 1; c <= 300 && extra < 3; c++) begin
      @(negedge clk);
      start_a = 1'b0; start_b = 1'b0;
      if (o_rd) n_reads++;
      if (finished) begin
        extra++;
        if (o_busy) busy_bad++;
      end
      if (o_done) begin
        n_done++;
        if (!o_busy) busy_bad++;
        if (done_cyc < 0) done_cyc = c;
        finished = 1'b1;
      end
      if (stall_left > 0 && stall_left < stall && !o_valid) hold_bad++;
      if (o_valid) begin
        if (stall_left > 0) begin
          if (stall_left == stall) held = o_data;
          else if (o_data != held) hold_bad++;
          tile_ready = 1'b0;
          stall_left--;
        end else begin
          tile_ready = 1'b1;
          if (n_tiles < 4) begin
            got[n_tiles]      = o_data;
            got_last[n_tiles] = o_last;
          end
          n_tiles++;
        end
      end else begin
        tile_ready = 1'b1;
      end
    end
    tile_ready = 1'b1;
    timed_out  = !finished;
  endtask

  vec_t vecs [9];
  int   hs;

  initial begin
    vecs[0] = '{1'b0, 24'h000010, 20'd8,  0,  2, 8,  32'h10111213, 32'h14151617, 32'h0};
    vecs[1] = '{1'b0, 24'h000020, 20'd5,  0,  2, 5,  32'h20212223, 32'h24000000, 32'h0};
    vecs[2] = '{1'b0, 24'h000000, 20'd4,  10, 1, 4,  32'h00010203, 32'h0,        32'h0};
    vecs[3] = '{1'b1, 24'h000040, 20'd2,  0,  1, 4,  32'h40414243, 32'h0,        32'h0};
    vecs[4] = '{1'b0, 24'h000055, 20'd0,  0,  0, 0,  32'h0,        32'h0,        32'h0};
    vecs[5] = '{1'b0, 24'hFFFFFE, 20'd3,  0,  1, 3,  32'hFEFF0000, 32'h0,        32'h0};
    vecs[6] = '{1'b0, 24'h000080, 20'd12, 2,  3, 12, 32'h80818283, 32'h84858687, 32'h88898A8B};
    vecs[7] = '{1'b1, 24'h000050, 20'd3,  4,  2, 6,  32'h50515253, 32'h54550000, 32'h0};
    vecs[8] = '{1'b0, 24'h000030, 20'd1,  3,  1, 1,  32'h30000000, 32'h0,        32'h0};

    #1;
    check("rst_a_outs", 64'({busy_a, rd_a, valid_a, last_a, done_a}), 64'd0);
    check("rst_a_data", 64'(tdata_a), 64'd0);
    check("rst_b_outs", 64'({busy_b, rd_b, valid_b, last_b, done_b}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 9; v++) begin
      run_xfer(vecs[v].s, vecs[v].addr, vecs[v].len, vecs[v].stall);
      check($sformatf("v%0d_timeout", v), 64'(timed_out), 64'd0);
      check($sformatf("v%0d_tiles", v), 64'(n_tiles), 64'(vecs[v].ntiles));
      check($sformatf("v%0d_reads", v), 64'(n_reads), 64'(vecs[v].nreads));
      check($sformatf("v%0d_done_cnt", v), 64'(n_done), 64'd1);
      check($sformatf("v%0d_busy", v), 64'(busy_bad), 64'd0);
      for (int i = 0; i < vecs[v].ntiles; i++) begin
        check($sformatf("v%0d_tile%0d", v, i), 64'(got[i]), 64'(exp_tile(vecs[v], i)));
        check($sformatf("v%0d_last%0d", v, i), 64'(got_last[i]), 64'(i == vecs[v].ntiles - 1));
      end
      if (vecs[v].stall > 0)
        check($sformatf("v%0d_hold", v), 64'(hold_bad), 64'd0);
      if (vecs[v].ntiles == 0)
        check($sformatf("v%0d_done_lat", v), 64'(done_cyc >= 1 && done_cyc <= 2), 64'd1);
    end

    // abort during the fetch of the second tile, then relaunch
    sel = 1'b0; tile_ready = 1'b1; hs = 0;
    @(negedge clk);
    dram_addr = 24'h000010; length = 20'd12; start_a = 1'b1;
    for (int c = 0; c < 100 && hs == 0; c++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (valid_a && tile_ready) hs++;
    end
    check("abort_hs_seen", 64'(hs), 64'd1);
    @(negedge clk);
    @(negedge clk);
    check("abort_in_fetch", 64'(rd_a), 64'd1);
    rst = 1'b1;
    #1;
    check("abort_outs", 64'({busy_a, rd_a, valid_a, last_a, done_a}), 64'd0);
    check("abort_addr", 64'(maddr_a), 64'd0);
    check("abort_data", 64'(tdata_a), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_xfer(1'b0, 24'h000010, 20'd8, 0);
    check("relaunch_timeout", 64'(timed_out), 64'd0);
    check("relaunch_tiles", 64'(n_tiles), 64'd2);
    check("relaunch_tile0", 64'(got[0]), 64'h10111213);
    check("relaunch_tile1", 64'(got[1]), 64'h14151617);
    check("relaunch_last1", 64'(got_last[1]), 64'd1);
    check("relaunch_done", 64'(n_done), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
